dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_req_fifo.sv | 61 ++++++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned TAG_W  = 11;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] MEM_BASE_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    MAINT = 2'd2
  } req_type_e;

  typedef struct packed {
    req_type_e         kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [TAG_W-1:0]  tag;
    logic              err;
    logic              cacheable;
    logic [CNT_W-1:0]  cnt;
  } req_entry_t;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request FIFO; every entry counts down its own response latency.
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       head_ready,
  output req_entry_t head
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  req_entry_t       loaded;
  req_entry_t       entries [DEPTH];

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head       = entries[rd_ptr[IDX_W-1:0]];
  assign head_ready = !empty && (head.cnt == '0);

  always_comb begin
    loaded     = push_entry;
    loaded.cnt = CNT_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload needs no reset; stale slots are masked by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && (wr_ptr[IDX_W-1:0] == IDX_W'(i))) begin
        entries[i] <= loaded;
      end else if (entries[i].cnt != '0) begin
        entries[i].cnt <= entries[i].cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: address decode, backing storage and response muxing.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MEM_BASE     = MEM_BASE_DEFAULT,
  parameter int unsigned       MEM_WORDS    = 1024,
  parameter int unsigned       RESP_LATENCY = 2,
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] mem_d_addr_i,
  input  logic [DATA_W-1:0] mem_d_data_wr_i,
  input  logic              mem_d_rd_i,
  input  logic [STRB_W-1:0] mem_d_wr_i,
  input  logic              mem_d_cacheable_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  input  logic              mem_d_invalidate_i,
  input  logic              mem_d_writeback_i,
  input  logic              mem_d_flush_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] mem_d_data_rd_o,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o
);

  localparam int unsigned     WORD_IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] MEM_LO     = {1'b0, MEM_BASE};
  localparam logic [ADDR_W:0] MEM_HI     = MEM_LO + 33'(4 * MEM_WORDS);

  logic                  req_present;
  logic                  push;
  logic                  full;
  logic                  head_ready;
  logic                  head_access;
  logic                  in_range;
  logic                  misaligned;
  logic                  is_maint;
  logic [ADDR_W:0]       addr_ext;
  logic [WORD_IDX_W-1:0] head_idx;
  req_entry_t            req;
  req_entry_t            head;
  logic [DATA_W-1:0]     storage [MEM_WORDS];
  logic                  unused_head;

  assign req_present    = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i |
                          mem_d_writeback_i | mem_d_flush_i;
  assign mem_d_accept_o = rst_ni & ~stall_i & ~full;
  assign push           = req_present & mem_d_accept_o;

  assign addr_ext   = {1'b0, mem_d_addr_i};
  assign in_range   = (addr_ext >= MEM_LO) && (addr_ext < MEM_HI);
  assign misaligned = |mem_d_addr_i[1:0];
  assign is_maint   = ~mem_d_rd_i & ~(|mem_d_wr_i);

  // Writes take priority over reads when both are requested.
  always_comb begin
    req           = '0;
    req.kind      = (|mem_d_wr_i) ? WRITE : (mem_d_rd_i ? READ : MAINT);
    req.addr      = mem_d_addr_i;
    req.data      = mem_d_data_wr_i;
    req.strb      = mem_d_wr_i;
    req.tag       = mem_d_req_tag_i;
    req.cacheable = mem_d_cacheable_i;
    req.err       = ~is_maint & (~in_range | misaligned);
  end

  dmem_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LATENCY (RESP_LATENCY)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (push),
    .push_entry (req),
    .pop        (head_ready),
    .full       (full),
    .head_ready (head_ready),
    .head       (head)
  );

  assign head_idx    = head.addr[WORD_IDX_W+1:2];
  assign head_access = head_ready & ~head.err;

  assign mem_d_ack_o      = head_ready;
  assign mem_d_error_o    = head_ready & head.err;
  assign mem_d_resp_tag_o = head_ready ? head.tag : '0;
  assign mem_d_data_rd_o  = (head_access && head.kind == READ) ? storage[head_idx] : '0;

  // Storage is deliberately left unreset; writes land in their response cycle.
  always_ff @(posedge clk_i) begin
    if (head_access && head.kind == WRITE) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (head.strb[b]) storage[head_idx][8*b +: 8] <= head.data[8*b +: 8];
      end
    end
  end

  assign unused_head = ^{head.addr[ADDR_W-1:WORD_IDX_W+2], head.addr[1:0],
                         head.cnt, head.cacheable};

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        rd, cacheable, inv, wb, flush, stall;
  logic [3:0]  wr;
  logic [10:0] tag, rtag;
  logic        accept, ack, err;

  logic        rst8_n, rd8, accept8, ack8, err8;
  logic [10:0] tag8, rtag8;
  logic [31:0] rdata8;

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 maintenance
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [10:0] tag;
    logic        err;
    int          due;
  } mreq_t;

  mreq_t       q [$];
  logic [31:0] mem_m [int];
  logic [31:0] addr_tab [12];
  logic [31:0] last_rd;
  int          cyc;
  int          total;
  int          bad;

  dmem_responder u_dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .mem_d_addr_i       (addr),
    .mem_d_data_wr_i    (wdata),
    .mem_d_rd_i         (rd),
    .mem_d_wr_i         (wr),
    .mem_d_cacheable_i  (cacheable),
    .mem_d_req_tag_i    (tag),
    .mem_d_invalidate_i (inv),
    .mem_d_writeback_i  (wb),
    .mem_d_flush_i      (flush),
    .stall_i            (stall),
    .mem_d_data_rd_o    (rdata),
    .mem_d_accept_o     (accept),
    .mem_d_ack_o        (ack),
    .mem_d_error_o      (err),
    .mem_d_resp_tag_o   (rtag)
  );

  dmem_responder #(
    .RESP_LATENCY (8),
    .FIFO_DEPTH   (4)
  ) u_dut8 (
    .clk_i              (clk),
    .rst_ni             (rst8_n),
    .mem_d_addr_i       (BASE),
    .mem_d_data_wr_i    (32'h0),
    .mem_d_rd_i         (rd8),
    .mem_d_wr_i         (4'h0),
    .mem_d_cacheable_i  (1'b0),
    .mem_d_req_tag_i    (tag8),
    .mem_d_invalidate_i (1'b0),
    .mem_d_writeback_i  (1'b0),
    .mem_d_flush_i      (1'b0),
    .stall_i            (1'b0),
    .mem_d_data_rd_o    (rdata8),
    .mem_d_accept_o     (accept8),
    .mem_d_ack_o        (ack8),
    .mem_d_error_o      (err8),
    .mem_d_resp_tag_o   (rtag8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4096) || (a[1:0] != 2'b00);
  endfunction

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic tick();
    logic        exp_acc, exp_ack, present;
    logic [31:0] exp_data, w;
    mreq_t       h, n;
    int          idx;
    @(negedge clk);
    present = rd || (wr != 4'h0) || inv || wb || flush;
    exp_acc = rst_n && !stall && (q.size() < DEPTH);
    exp_ack = rst_n && (q.size() > 0) && (q[0].due <= cyc);
    check("accept", 32'(accept), 32'(exp_acc));
    check("ack", 32'(ack), 32'(exp_ack));
    if (exp_ack) begin
      h = q[0];
      check("resp_tag", 32'(rtag), 32'(h.tag));
      check("resp_err", 32'(err), 32'(h.err));
      idx = int'((h.addr - BASE) >> 2);
      if (h.kind == 0 && !h.err) begin
        if (mem_m.exists(idx)) check("rd_data", rdata, mem_m[idx]);
      end else begin
        check("nonread_data", rdata, 32'h0);
      end
    end else begin
      check("idle_data", rdata, 32'h0);
      check("idle_err_tag", {20'h0, err, rtag}, 32'h0);
    end
    if (ack) last_rd = rdata;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (exp_ack) begin
        if (h.kind == 1 && !h.err) begin
          w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          for (int b = 0; b < 4; b++) if (h.strb[b]) w[8*b +: 8] = h.data[8*b +: 8];
          if (mem_m.exists(idx) || h.strb == 4'hF) mem_m[idx] = w;
        end
        void'(q.pop_front());
      end
      if (present && exp_acc) begin
        n.kind = (wr != 4'h0) ? 1 : (rd ? 0 : 2);
        n.addr = addr;
        n.data = wdata;
        n.strb = wr;
        n.tag  = tag;
        n.err  = (n.kind != 2) && addr_err(addr);
        n.due  = cyc + LAT;
        q.push_back(n);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [10:0] t,
                       input logic [2:0] m, input logic s);
    rd = r; wr = w; addr = a; wdata = d; tag = t;
    inv = m[0]; wb = m[1]; flush = m[2]; stall = s;
    cacheable = 1'($urandom);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 32'h0, 32'h0, 11'h0, 3'b000, 1'b0);
  endtask

  initial begin
    int q8_due [$];
    logic [10:0] q8_tag [$];
    int sent8, k5, first_ack8, r;
    logic e_acc, e_ack;

    total = 0; bad = 0; cyc = 0; last_rd = 32'h0;
    addr_tab = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd16,
                 BASE + 32'd28, BASE + 32'd4092, BASE + 32'd1, BASE + 32'd4096,
                 BASE - 32'd4, 32'h9000_0000, BASE + 32'd6};
    rst_n = 1'b0; rst8_n = 1'b0; rd8 = 1'b0; tag8 = '0;
    rd = 0; wr = 0; addr = 0; wdata = 0; tag = 0; inv = 0; wb = 0; flush = 0;
    stall = 0; cacheable = 0;
    @(posedge clk); #1;

    idle(3);
    rst_n = 1'b1; rst8_n = 1'b1;

    // Full write then read-back; byte-lane merge; out-of-range write.
    drive(1'b0, 4'hF, BASE, 32'hDEADAEEF, 11'd5, 3'b000, 1'b0);
    drive(1'b1, 4'h0, BASE, 32'h0, 11'd6, 3'b000, 1'b0);
    idle(3);
    check("rd_after_wr", last_rd, 32'hDEADAEEF);
    drive(1'b0, 4'hF, 32'h9000_0000, 32'hDEADAEEF, 11'd7, 3'b000, 1'b0);
    drive(1'b1, 4'h0, BASE, 32'h0, 11'd8, 3'b000, 1'b0);
    idle(3);
    check("rd_after_bad_wr", last_rd, 32'hDEADAEEF);
    drive(1'b0, 4'b0010, BASE, 32'h0000AB00, 11'd9, 3'b000, 1'b0);
    drive(1'b1, 4'h0, BASE, 32'h0, 11'd10, 3'b000, 1'b0);
    idle(3);
    check("byte_merge", last_rd, 32'hDEADABEF);

    for (int i = 1; i < 7; i++)
      drive(1'b0, 4'hF, addr_tab[i], $urandom, 11'(11 + i), 3'b000, 1'b0);
    idle(3);

    // Stall with reads pending, then a back-to-back burst.
    drive(1'b1, 4'h0, BASE + 32'd4, 32'h0, 11'd30, 3'b000, 1'b0);
    drive(1'b1, 4'h0, BASE + 32'd8, 32'h0, 11'd31, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h0, BASE, 32'h0, 11'd32, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h0, addr_tab[i], 32'h0, 11'(32 + i), 3'b000, 1'b0);
    idle(4);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 13));
      if (r < 4)
        drive(1'b1, 4'h0, addr_tab[$urandom_range(0, 11)], $urandom, 11'($urandom), 3'b000, ($urandom_range(0, 9) == 0));
      else if (r < 7)
        drive(1'b0, 4'($urandom_range(1, 15)), addr_tab[$urandom_range(0, 11)], $urandom, 11'($urandom), 3'b000, ($urandom_range(0, 9) == 0));
      else if (r == 7)
        drive(1'b1, 4'($urandom_range(1, 15)), addr_tab[$urandom_range(0, 11)], $urandom, 11'($urandom), 3'b000, 1'b0);
      else if (r < 10)
        drive(1'b0, 4'h0, addr_tab[$urandom_range(0, 11)], $urandom, 11'($urandom), 3'($urandom_range(1, 7)), 1'b0);
      else
        idle(1);
    end
    idle(4);

    // Reset with a request outstanding discards it.
    drive(1'b1, 4'h0, BASE, 32'h0, 11'd40, 3'b000, 1'b0);
    drive(1'b1, 4'h0, BASE + 32'd4, 32'h0, 11'd41, 3'b000, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);

    // Long-latency instance: fill to depth and watch accept recover.
    sent8 = 0; k5 = -1; first_ack8 = -1;
    for (int k = 0; k < 24; k++) begin
      rd8 = (sent8 < 5);
      tag8 = 11'(sent8);
      @(negedge clk);
      e_acc = (q8_due.size() < 4);
      e_ack = (q8_due.size() > 0) && (q8_due[0] <= k);
      check("acc8", 32'(accept8), 32'(e_acc));
      check("ack8", 32'(ack8), 32'(e_ack));
      if (e_ack) check("tag8", 32'(rtag8), 32'(q8_tag[0]));
      if (ack8) check("err8", 32'(err8), 32'h0);
      if (ack8 && first_ack8 < 0) first_ack8 = k;
      if (sent8 == 4 && accept8 && k5 < 0) k5 = k;
      @(posedge clk);
      if (e_ack) begin
        void'(q8_due.pop_front());
        void'(q8_tag.pop_front());
      end
      if (rd8 && e_acc) begin
        q8_due.push_back(k + 8);
        q8_tag.push_back(11'(sent8));
        sent8++;
      end
      #1;
    end
    check("first_ack8_cycle", 32'(first_ack8), 32'd8);
    check("fifth_accept_cycle", 32'(k5), 32'(first_ack8 + 1));

    for (int k = 0; k < 3; k++) begin
      rd8 = 1'b1;
      tag8 = 11'(20 + k);
      @(negedge clk);
      check("acc8_pre_rst", 32'(accept8), 32'h1);
      @(posedge clk); #1;
    end
    rst8_n = 1'b0;
    rd8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("acc8_in_rst", 32'(accept8), 32'h0);
      check("ack8_in_rst", 32'(ack8), 32'h0);
      @(posedge clk); #1;
    end
    rst8_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) check("acc8_after_rst", 32'(accept8), 32'h1);
      check("ack8_after_rst", 32'(ack8), 32'h0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
